// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage registers.
package pipe_pkg;

    // Control-bus bit positions shared by every stage boundary
    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMWRITE    = 1;
    localparam int CTRL_MEMTOREG_LO = 2;
    localparam int CTRL_MEMTOREG_HI = 4;

    // PC value presented by an empty stage after reset
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Payload widths of each stage boundary
    localparam int FD_PAYLOAD_W = 32;   // IR
    localparam int DE_PAYLOAD_W = 160;  // IR, RS, RT, imm, PC+8
    localparam int EM_PAYLOAD_W = 128;  // IR, RT, ALUOut, PC+8
    localparam int MW_PAYLOAD_W = 160;  // IR, ALUOut, DM data, HI, LO

    // Stage occupancy decoded from {main_v, skid_v}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } slot_state_e;

    // Number of live entries held by the stage
    function automatic logic [1:0] live_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One stage entry register {valid, pc, payload, ctrl} with load and kill.
module pipe_stage_skid_slot
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = 160,
    parameter int          CTRL_W    = 5,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 kill,
    input  logic [31:0]          d_pc,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [CTRL_W-1:0]    d_ctrl,
    output logic                 valid,
    output logic [31:0]          pc,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [CTRL_W-1:0]    ctrl
);

    // Entry register: kill only drops the valid bit, data keeps its stale value
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
        if (reset) begin
            // NOTE: data registers are reset too, because the main slot's data is visible right after reset.
            valid   <= 1'b0;
            pc      <= PC_RESET;
            payload <= '0;
            ctrl    <= '0;
        end else if (kill) begin
            valid   <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            pc      <= d_pc;
            payload <= d_payload;
            ctrl    <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = 160,
    parameter int          CTRL_W    = 5,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 main_v, skid_v;
    logic [31:0]          main_pc, skid_pc, main_d_pc;
    logic [PAYLOAD_W-1:0] main_payload, skid_payload, main_d_payload;
    logic [CTRL_W-1:0]    main_ctrl, skid_ctrl, main_d_ctrl;
    logic                 main_load, main_kill, skid_load, skid_kill;
    logic                 accept, issue;
    slot_state_e          state;

    assign state     = slot_state_e'({main_v, skid_v});
    assign in_ready  = ~skid_v & ~reset;
    assign accept    = in_valid & in_ready;
    assign issue     = main_v & out_ready;

    // Main slot refills from the skid entry when one is waiting, keeping FIFO order
    assign main_d_pc      = skid_v ? skid_pc      : in_pc;
    assign main_d_payload = skid_v ? skid_payload : in_payload;
    assign main_d_ctrl    = skid_v ? skid_ctrl    : in_ctrl;

    assign out_valid   = main_v;
    assign out_pc      = main_pc;
    assign out_payload = main_payload;
    assign out_ctrl    = main_v ? main_ctrl : '0;
    assign occupancy   = live_count(main_v, skid_v);

    // Next-state decode: flush empties both slots, otherwise move entries per handshake
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        main_load = 1'b0;
        main_kill = 1'b0;
        skid_load = 1'b0;
        skid_kill = 1'b0;
        if (flush) begin
            main_kill = 1'b1;
            skid_kill = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept && issue) main_load = 1'b1;
                    else if (accept)     skid_load = 1'b1;
                    else if (issue)      main_kill = 1'b1;
                end
                ST_TWO: begin
                    if (issue) begin
                        main_load = 1'b1;
                        skid_kill = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_stage_skid_slot #(
        .PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .PC_RESET(PC_RESET)
    ) u_main (
        .clk(clk), .reset(reset), .load(main_load), .kill(main_kill),
        .d_pc(main_d_pc), .d_payload(main_d_payload), .d_ctrl(main_d_ctrl),
        .valid(main_v), .pc(main_pc), .payload(main_payload), .ctrl(main_ctrl)
    );

    pipe_stage_skid_slot #(
        .PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .PC_RESET(PC_RESET)
    ) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .kill(skid_kill),
        .d_pc(in_pc), .d_payload(in_payload), .d_ctrl(in_ctrl),
        .valid(skid_v), .pc(skid_pc), .payload(skid_payload), .ctrl(skid_ctrl)
    );

    // Saturating count of cycles the downstream holds off a live entry; flush does not clear it
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (main_v && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int          PW      = 160;
    localparam int          CW      = 5;
    localparam int          CNTW    = 4;
    localparam int          CNT_MAX = (1 << CNTW) - 1;
    localparam logic [31:0] PC_RST  = 32'h0000_3000;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_pc, out_pc;
    logic [PW-1:0]   in_payload, out_payload;
    logic [CW-1:0]   in_ctrl, out_ctrl;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    typedef struct {
        logic [31:0]   pc;
        logic [PW-1:0] pl;
        logic [CW-1:0] ct;
    } ent_t;

    ent_t q[$];
    int   cnt   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PAYLOAD_W(PW), .CTRL_W(CW), .PC_RESET(PC_RST), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_payload(in_payload), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_payload(out_payload), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] v;
        for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Compare every DUT output against the model's view of the stage
    task automatic check_outputs();
        logic exp_v;
        exp_v = (q.size() != 0);
        chk("out_valid", PW'(out_valid), PW'(exp_v));
        chk("in_ready", PW'(in_ready), PW'(!reset && q.size() < 2));
        chk("occupancy", PW'(occupancy), PW'(q.size()));
        chk("stall_cnt", PW'(stall_cnt), PW'(cnt));
        if (exp_v) begin
            chk("out_ctrl", PW'(out_ctrl), PW'(q[0].ct));
            chk("out_pc", PW'(out_pc), PW'(q[0].pc));
            chk("out_payload", out_payload, q[0].pl);
        end else begin
            chk("out_ctrl_bubble", PW'(out_ctrl), '0);
        end
    endtask

    // One clock: drive inputs at negedge, check, then advance model over the posedge
    task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                        input logic [CW-1:0] ct, input logic ordy);
        logic [PW-1:0] pl;
        bit acc, iss;
        pl = rand_payload();
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_pc = pc;
        in_payload = pl; in_ctrl = ct; out_ready = ordy;
        #1;
        check_outputs();
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = 0;
        end else begin
            acc = iv && (q.size() < 2);
            iss = (q.size() > 0) && ordy;
            if (q.size() > 0 && !ordy && cnt < CNT_MAX) cnt++;
            if (f) q.delete();
            else begin
                if (iss) void'(q.pop_front());
                if (acc) q.push_back('{pc, pl, ct});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_payload = '0; in_ctrl = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", PW'(out_valid), '0);
        chk("rst_out_pc", PW'(out_pc), PW'(32'h0000_3000));
        chk("rst_out_payload", out_payload, '0);
        chk("rst_out_ctrl", PW'(out_ctrl), '0);
        chk("rst_stall_cnt", PW'(stall_cnt), '0);
        chk("rst_in_ready", PW'(in_ready), '0);
        chk("rst_occupancy", PW'(occupancy), '0);

        // Stream back-to-back with out_ready high
        step(0, 0, 1, 32'h3000, 5'h01, 1);
        step(0, 0, 1, 32'h3004, 5'h02, 1);
        step(0, 0, 1, 32'h3008, 5'h03, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);

        // Backpressure: 0x3008 must wait upstream, then drain in order
        step(0, 0, 1, 32'h3000, 5'h11, 0);
        step(0, 0, 1, 32'h3004, 5'h12, 0);
        step(0, 0, 1, 32'h3008, 5'h13, 0);
        step(0, 0, 1, 32'h3008, 5'h13, 0);
        step(0, 0, 1, 32'h3008, 5'h13, 1);
        step(0, 0, 1, 32'h3008, 5'h13, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);

        // Flush at TWO with a same-cycle input that must be dropped
        step(0, 0, 1, 32'h3000, 5'h07, 0);
        step(0, 0, 1, 32'h3004, 5'h07, 0);
        step(0, 1, 1, 32'h300C, 5'h07, 0);
        step(0, 0, 0, 32'h0,    5'h00, 1);
        step(0, 0, 0, 32'h0,    5'h00, 1);

        // Bubble: control on the bus without in_valid never reaches out_ctrl
        step(0, 0, 0, 32'h3010, 5'b00011, 1);
        step(0, 0, 0, 32'h3010, 5'b00011, 1);
        step(0, 0, 0, 32'h3010, 5'b00011, 0);

        // Saturation of the stall counter, survival across flush, clear on reset
        step(0, 0, 1, 32'h3020, 5'h1F, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 5'h00, 0);
        chk("stall_saturated", PW'(stall_cnt), PW'(15));
        step(0, 1, 0, 32'h0, 5'h00, 0);
        step(0, 0, 0, 32'h0, 5'h00, 0);
        chk("stall_after_flush", PW'(stall_cnt), PW'(15));
        step(1, 0, 0, 32'h0, 5'h00, 0);
        step(0, 0, 0, 32'h0, 5'h00, 0);
        chk("stall_after_reset", PW'(stall_cnt), '0);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 32'h3000 + 32'(i * 4),
                 5'($urandom), ($urandom_range(0, 9) < 6));
        end
        step(0, 0, 0, 32'h0, 5'h00, 1);
        step(0, 0, 0, 32'h0, 5'h00, 1);
        step(0, 0, 0, 32'h0, 5'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
